// File: rtl/rv_regfile.sv
// RV32I integer register file: two async read ports, one sync write port, post-reset clear sequencer.
// Optional same-cycle write-through forwarding when RV_REGFILE_BYPASS_EN is defined.
//
// state | meaning
// CLEAR | zeroing x1..x(NREGS-1) one per cycle, busy=1, writes ignored
// READY | normal operation, write-back accepted
module rv_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] rs2,
    output logic            busy
);

    typedef enum logic {CLEAR, READY} state_t;

    state_t          state;
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] mem [0:NREGS-1];

    // Entry 0 is never written; x0 is produced by the read mux.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            idx   <= AW'(1);
        end else begin
            case (state)
                CLEAR: begin
                    mem[idx] <= '0;
                    if (idx == AW'(NREGS - 1)) begin
                        state <= READY;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                READY: begin
                    if (we && waddr != '0) begin
                        mem[waddr] <= wdata;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    assign busy = (state == CLEAR);

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        logic [XLEN-1:0] val;
        if (busy || addr == '0) begin
            val = '0;
`ifdef RV_REGFILE_BYPASS_EN
        end else if (we && waddr != '0 && waddr == addr) begin
            val = wdata;
`endif
        end else begin
            val = mem[addr];
        end
        return val;
    endfunction

    assign rs1 = read_port(raddr1);
    assign rs2 = read_port(raddr2);

endmodule

// File: tb/tb_rv_regfile.sv
// Self-checking bench for rv_regfile: directed scenarios plus randomized traffic
// compared every cycle against an array-based reference model.
module tb_rv_regfile;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic [AW-1:0]   raddr1;
    logic [AW-1:0]   raddr2;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            busy;

    int checks = 0;
    int errors = 0;

    rv_regfile #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Reference model: edges since last reset release (saturating), and register contents.
    int              since_rel = 0;
    bit              model_ok  = 1'b0;
    logic [XLEN-1:0] model_mem [0:NREGS-1];

    always @(posedge clk) begin
        if (rst) begin
            since_rel = 0;
            model_ok  = 1'b1;
        end else if (model_ok) begin
            if (since_rel < NREGS - 1) begin
                since_rel = since_rel + 1;
                model_mem[since_rel] = '0;
            end else if (we && waddr != 0) begin
                model_mem[waddr] = wdata;
            end
        end
    end

    function automatic logic model_busy();
        return since_rel < NREGS - 1;
    endfunction

    function automatic logic [XLEN-1:0] model_read(input logic [AW-1:0] a);
        if (model_busy() || a == 0) return '0;
`ifdef RV_REGFILE_BYPASS_EN
        if (we && waddr != 0 && waddr == a) return wdata;
`endif
        return model_mem[a];
    endfunction

    task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_ok && !rst) begin
            check("busy_model", {31'b0, busy}, {31'b0, model_busy()});
            check("rs1_model", rs1, model_read(raddr1));
            check("rs2_model", rs2, model_read(raddr2));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        we = 1'b1; waddr = a; wdata = d;
        step();
        we = 1'b0;
    endtask

    int n;

    initial begin
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        check("busy_in_reset", {31'b0, busy}, 32'd1);

        // Release, count edges until busy drops; inject a write at cycle 3 of the clear.
        @(posedge clk); #1;
        rst = 1'b0;
        raddr1 = 5'd7;
        n = 0;
        while (n < 100) begin
            if (n == 2) begin
                we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678;
                @(negedge clk);
                check("rs1_during_busy", rs1, 32'h0);
            end
            step();
            n = n + 1;
            we = 1'b0;
            if (!busy) break;
        end
        check("clear_edges", n, 32'd31);

        for (int a = 0; a < NREGS; a++) begin
            raddr1 = AW'(a);
            raddr2 = AW'(NREGS - 1 - a);
            #1;
            check("cleared_rs1", rs1, 32'h0);
            check("cleared_rs2", rs2, 32'h0);
        end
        raddr1 = 5'd7;
        #1;
        check("busy_write_dropped", rs1, 32'h0);

        wr(5'd5, 32'h0000_0001);
        wr(5'd6, 32'h0000_0005);
        raddr1 = 5'd5; raddr2 = 5'd6;
        @(negedge clk);
        check("read_x5", rs1, 32'h1);
        check("read_x6", rs2, 32'h5);

        wr(5'd0, 32'hDEAD_BEEF);
        raddr1 = 5'd0; raddr2 = 5'd0;
        @(negedge clk);
        check("x0_rs1", rs1, 32'h0);
        check("x0_rs2", rs2, 32'h0);

        wr(5'd9, 32'hAAAA_AAAA);
        we = 1'b1; waddr = 5'd9; wdata = 32'h5555_5555; raddr1 = 5'd9; raddr2 = 5'd9;
        @(negedge clk);
`ifdef RV_REGFILE_BYPASS_EN
        check("same_cycle_rs1", rs1, 32'h5555_5555);
`else
        check("same_cycle_rs1", rs1, 32'hAAAA_AAAA);
`endif
        check("same_cycle_equal_ports", rs2, rs1);
        step();
        we = 1'b0;
        @(negedge clk);
        check("after_edge_rs1", rs1, 32'h5555_5555);

        // Reset mid-clear.
        @(posedge clk); #1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        while (n < 100) begin
            step();
            n = n + 1;
            if (!busy) break;
        end
        check("restart_edges", n, 32'd31);
        raddr1 = 5'd9;
        #1;
        check("restart_cleared_x9", rs1, 32'h0);

        // Randomized traffic; the negedge process compares against the model.
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 599) == 0);
            we     = ($urandom_range(0, 2) != 0);
            waddr  = AW'($urandom_range(0, NREGS - 1));
            wdata  = $urandom;
            raddr1 = AW'($urandom_range(0, NREGS - 1));
            case ($urandom_range(0, 3))
                0: raddr2 = raddr1;
                1: raddr2 = waddr;
                default: raddr2 = AW'($urandom_range(0, NREGS - 1));
            endcase
            if ($urandom_range(0, 3) == 0) raddr1 = waddr;
            step();
        end

        rst = 1'b0;
        idle_inputs();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
